// File: rtl/frame_assembler.sv
// frame_assembler: ping-pong frame builder, header block plus NCH slot-addressed channel regions.
// Define FRAME_ASM_DROP_CNT_EN to count out-of-range slot writes into header word 3.
module frame_assembler #(
    parameter int NCH       = 4,
    parameter int DW        = 32,
    parameter int SLOTS     = 128,
    parameter int HDR_WORDS = 16,
    localparam int AW       = $clog2(HDR_WORDS + NCH * SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_msync_n,
    input  logic [31:0]       i_sync_counter,
    input  logic [31:0]       i_ms_counter,
    input  logic [NCH*DW-1:0] i_ch_data,
    input  logic [NCH*16-1:0] i_ch_slot,
    input  logic [NCH-1:0]    i_ch_valid,
    output logic [NCH-1:0]    o_ch_ready,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DW-1:0]     o_rd_data,
    output logic              o_frame_done,
    output logic              o_rd_bank,
    output logic [31:0]       o_frame_cnt
);

    localparam int DEPTH = HDR_WORDS + NCH * SLOTS;
    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HW    = $clog2(HDR_WORDS);
    localparam logic [AW:0] LIM = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            sync1;
    logic            sync2;
    logic            sync3;
    logic            msync;
    logic            wr_bank;
    logic [HW-1:0]   hdr_idx;
    logic [PW-1:0]   last;
    logic [PW-1:0]   gidx;
    logic            found;
    logic [NCH-1:0]  grant;
    logic            xfer;
    logic [15:0]     slot;
    logic [DW-1:0]   cdata;
    logic            in_range;
    logic [DW-1:0]   hdr_word;
    logic [31:0]     drop_word;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            in_map;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    function automatic logic [PW-1:0] rr(input logic [PW-1:0] base, input int i);
        return PW'((int'(base) + i) % NCH);
    endfunction

    // Main sync: two-flop synchroniser plus an edge register for the falling-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= i_msync_n;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign msync = sync3 & ~sync2;

    // Round-robin search starting after the last granted channel.
    always_comb begin
        found = 1'b0;
        gidx  = last;
        for (int i = 1; i <= NCH; i++) begin
            if (!found && i_ch_valid[rr(last, i)]) begin
                found = 1'b1;
                gidx  = rr(last, i);
            end
        end
        grant = '0;
        if (found && state_q == S_DATA && !msync) begin
            grant = NCH'(1) << gidx;
        end
    end

    assign o_ch_ready = grant;
    assign xfer       = |grant;
    assign slot       = i_ch_slot[int'(gidx)*16 +: 16];
    assign cdata      = i_ch_data[int'(gidx)*DW +: DW];
    assign in_range   = int'(slot) < SLOTS;

`ifdef FRAME_ASM_DROP_CNT_EN
    logic [31:0] drop_cnt;
    logic [31:0] drop_last;

    // Drops in the running frame; latched and cleared at each main sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt  <= '0;
            drop_last <= '0;
        end else if (msync) begin
            drop_last <= drop_cnt;
            drop_cnt  <= '0;
        end else if (xfer && !in_range && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign drop_word = drop_last;
`else
    assign drop_word = '0;
`endif

    // Header word contents, sampled in the cycle the word is written.
    always_comb begin
        hdr_word = '0;
        if (hdr_idx == HW'(0)) hdr_word = DW'(i_sync_counter);
        if (hdr_idx == HW'(1)) hdr_word = DW'(o_frame_cnt);
        if (hdr_idx == HW'(2)) hdr_word = DW'(i_ms_counter);
        if (hdr_idx == HW'(3)) hdr_word = DW'(drop_word);
    end

    // Next state and RAM write port.
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        if (msync) begin
            state_d = S_HDR;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_HDR: begin
                    we    = 1'b1;
                    waddr = AW'(hdr_idx);
                    wdata = hdr_word;
                    if (hdr_idx == HW'(HDR_WORDS - 1)) state_d = S_DATA;
                end
                S_DATA: begin
                    if (xfer && in_range) begin
                        we    = 1'b1;
                        waddr = AW'(HDR_WORDS + int'(gidx) * SLOTS + int'(slot));
                        wdata = cdata;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Bank swap, frame counting, header index and arbiter pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank      <= 1'b0;
            o_rd_bank    <= 1'b1;
            o_frame_cnt  <= '0;
            o_frame_done <= 1'b0;
            hdr_idx      <= '0;
            last         <= PW'(NCH - 1);
        end else begin
            o_frame_done <= msync && state_q != S_IDLE;
            if (msync) begin
                hdr_idx <= '0;
                if (state_q != S_IDLE) begin
                    wr_bank     <= ~wr_bank;
                    o_rd_bank   <= wr_bank;
                    o_frame_cnt <= o_frame_cnt + 32'd1;
                end
            end else if (state_q == S_HDR) begin
                hdr_idx <= hdr_idx + HW'(1);
            end
            if (xfer) last <= gidx;
        end
    end

    // Ping-pong RAM write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_bank) mem1[waddr] <= wdata;
            else         mem0[waddr] <= wdata;
        end
    end

    assign in_map = {1'b0, i_rd_addr} < LIM;

    // Registered read of the closed bank; outside the frame map reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data <= '0;
        end else if (in_map) begin
            o_rd_data <= o_rd_bank ? mem1[i_rd_addr] : mem0[i_rd_addr];
        end else begin
            o_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// tb_frame_assembler: random channel traffic against a frame-level reference model.
// Honours FRAME_ASM_DROP_CNT_EN for the expected header word 3.
`timescale 1ns/1ps
module tb_frame_assembler;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int SLOTS = 128;
    localparam int HDR   = 16;
    localparam int DEPTH = HDR + NCH * SLOTS;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [15:0] slot;
        logic [31:0] data;
    } item_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_msync_n;
    logic [31:0]       i_sync_counter;
    logic [31:0]       i_ms_counter;
    logic [NCH*DW-1:0] i_ch_data;
    logic [NCH*16-1:0] i_ch_slot;
    logic [NCH-1:0]    i_ch_valid;
    logic [NCH-1:0]    o_ch_ready;
    logic [AW-1:0]     i_rd_addr;
    logic [DW-1:0]     o_rd_data;
    logic              o_frame_done;
    logic              o_rd_bank;
    logic [31:0]       o_frame_cnt;

    int checks   = 0;
    int failures = 0;

    item_t       q [NCH][$];
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    int          m_state;
    int          m_hidx;
    int          m_wbank;
    int          m_rbank;
    logic [31:0] m_fcnt;
    logic [31:0] m_drops;
    logic [31:0] m_dlast;
    int          m_last;
    bit          m_done;
    int          msc;

    always #5 clk = ~clk;

    frame_assembler #(
        .NCH(NCH),
        .DW(DW),
        .SLOTS(SLOTS),
        .HDR_WORDS(HDR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_msync_n(i_msync_n),
        .i_sync_counter(i_sync_counter),
        .i_ms_counter(i_ms_counter),
        .i_ch_data(i_ch_data),
        .i_ch_slot(i_ch_slot),
        .i_ch_valid(i_ch_valid),
        .o_ch_ready(o_ch_ready),
        .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data),
        .o_frame_done(o_frame_done),
        .o_rd_bank(o_rd_bank),
        .o_frame_cnt(o_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_hidx  = 0;
        m_wbank = 0;
        m_rbank = 1;
        m_fcnt  = '0;
        m_drops = '0;
        m_dlast = '0;
        m_last  = NCH - 1;
        m_done  = 1'b0;
        msc     = -1;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) m_known[b][a] = 1'b0;
    endtask

    task automatic push(input int c, input int s, input logic [31:0] d);
        item_t it;
        it.slot = 16'(s);
        it.data = d;
        q[c].push_back(it);
    endtask

    // One clock: present queued items, check outputs, then advance the model.
    task automatic cycle();
        logic [NCH-1:0] er;
        logic [31:0]    hv;
        item_t          it;
        int             g;
        int             a;
        bit             ms;
        for (int c = 0; c < NCH; c++) begin
            if (q[c].size() > 0) begin
                i_ch_valid[c]          = 1'b1;
                i_ch_slot[c*16 +: 16]  = q[c][0].slot;
                i_ch_data[c*DW +: DW]  = q[c][0].data;
            end else begin
                i_ch_valid[c] = 1'b0;
            end
        end
        ms = (msc == 0);
        if (ms) i_msync_n = 1'b1;
        #1;
        er = '0;
        g  = -1;
        if (m_state == 2 && !ms) begin
            for (int i = 1; i <= NCH; i++) begin
                int c;
                c = (m_last + i) % NCH;
                if (g < 0 && i_ch_valid[c]) g = c;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("ready", 32'(o_ch_ready), 32'(er));
        check("frame_done", 32'(o_frame_done), 32'(m_done));
        check("rd_bank", 32'(o_rd_bank), 32'(m_rbank));
        check("frame_cnt", o_frame_cnt, m_fcnt);
        @(posedge clk);
        m_done = 1'b0;
        if (ms) begin
            if (m_state != 0) begin
                m_rbank = m_wbank;
                m_wbank = 1 - m_wbank;
                m_fcnt  = m_fcnt + 1;
                m_done  = 1'b1;
            end
            m_dlast = m_drops;
            m_drops = '0;
            m_state = 1;
            m_hidx  = 0;
        end else if (m_state == 1) begin
            case (m_hidx)
                0: hv = i_sync_counter;
                1: hv = m_fcnt;
                2: hv = i_ms_counter;
`ifdef FRAME_ASM_DROP_CNT_EN
                3: hv = m_dlast;
`else
                3: hv = '0;
`endif
                default: hv = '0;
            endcase
            m_mem[m_wbank][m_hidx]   = hv;
            m_known[m_wbank][m_hidx] = 1'b1;
            m_hidx++;
            if (m_hidx == HDR) m_state = 2;
        end else if (m_state == 2 && g >= 0) begin
            it     = q[g].pop_front();
            m_last = g;
            if (int'(it.slot) < SLOTS) begin
                a = HDR + g * SLOTS + int'(it.slot);
                m_mem[m_wbank][a]   = it.data;
                m_known[m_wbank][a] = 1'b1;
            end else if (m_drops != 32'hFFFF_FFFF) begin
                m_drops = m_drops + 1;
            end
        end
        if (msc >= 0) msc--;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic fire();
        i_msync_n = 1'b0;
        msc       = 2;
    endtask

    task automatic feed();
        for (int c = 0; c < NCH; c++) begin
            if (q[c].size() < 3 && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 15) == 0)
                    push(c, $urandom_range(SLOTS, 400), $urandom);
                else
                    push(c, $urandom_range(0, SLOTS - 1), $urandom);
            end
        end
    endtask

    task automatic rd(input int a);
        logic [31:0] exp;
        bit          k;
        i_rd_addr = AW'(a);
        if (a >= DEPTH) begin
            k   = 1'b1;
            exp = '0;
        end else begin
            k   = m_known[m_rbank][a];
            exp = m_mem[m_rbank][a];
        end
        cycle();
        if (k) check("rd_data", o_rd_data, exp);
    endtask

    initial begin
        int gap;
        rst_n          = 1'b0;
        i_msync_n      = 1'b1;
        i_sync_counter = '0;
        i_ms_counter   = '0;
        i_ch_data      = '0;
        i_ch_slot      = '0;
        i_ch_valid     = '0;
        i_rd_addr      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(o_ch_ready), 32'h0);
        check("rst_done", 32'(o_frame_done), 32'h0);
        check("rst_rd_bank", 32'(o_rd_bank), 32'h1);
        check("rst_frame_cnt", o_frame_cnt, 32'h0);
        check("rst_rd_data", o_rd_data, 32'h0);
        rst_n = 1'b1;
        run(3);

        i_sync_counter = 32'hA5A5_0001;
        i_ms_counter   = 32'd1000;
        fire();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++)
                push(c, s, (32'(c) << 16) | 32'(s));
        for (int i = 0; i < 3; i++) push(2, 200, 32'hDEAD_0000);
        run(60);
        i_sync_counter = $urandom;
        i_ms_counter   = $urandom;
        fire();
        run(4);
        for (int a = 0; a < 4; a++) rd(a);
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++)
                rd(HDR + c * SLOTS + s);

        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 10; i++)
                push(c, $urandom_range(0, SLOTS - 1), $urandom);
        run(50);
        fire();
        run(4);
        for (int a = 0; a < 4; a++) rd(a);

        for (int f = 0; f < 6; f++) begin
            i_sync_counter = $urandom;
            i_ms_counter   = $urandom;
            fire();
            gap = (f == 2) ? 5 : $urandom_range(30, 60);
            for (int i = 0; i < gap; i++) begin
                feed();
                cycle();
            end
        end
        fire();
        run(4);
        for (int a = 0; a < DEPTH; a++) rd(a);
        rd(DEPTH);
        rd(DEPTH + 5);
        rd((1 << AW) - 1);

        for (int c = 0; c < NCH; c++) push(c, 1, $urandom);
        cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(o_ch_ready), 32'h0);
        check("midrst_frame_cnt", o_frame_cnt, 32'h0);
        check("midrst_rd_bank", 32'(o_rd_bank), 32'h1);
        check("midrst_done", 32'(o_frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
